// File: rtl/fifo_pkg.sv
// Shared constants and pointer/address type helpers for the synchronous FIFO.
// Types only; modules derive their own widths from ADDR_WIDTH.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;

  typedef logic [FIFO_ADDR_WIDTH:0]   fifo_ptr_t;
  typedef logic [FIFO_ADDR_WIDTH-1:0] fifo_addr_t;

endpackage : fifo_pkg

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the synchronous FIFO register-file storage.
// Optional FIFO_LEVEL_EN macro adds the occupancy output port `level`.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam ptr_t PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam ptr_t PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};

  ptr_t wr_ptr_r;
  ptr_t rd_ptr_r;
  logic full_s;
  logic empty_s;
  logic accept_w_s;
  logic accept_r_s;

  // Flags and accept qualifiers derived purely from the pointer registers.
  always_comb begin
    empty_s    = 1'b0;
    full_s     = 1'b0;
    accept_w_s = 1'b0;
    accept_r_s = 1'b0;
    if (wr_ptr_r == rd_ptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    // Extra MSB distinguishes a full ring from an empty one.
    if ((wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
        (addr_t'(wr_ptr_r) == addr_t'(rd_ptr_r))) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    accept_w_s = wr & ~full_s;
    accept_r_s = rd & ~empty_s;
  end

  // Pointer registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (accept_w_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (accept_r_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign full   = full_s;
  assign empty  = empty_s;
  assign wr_en  = accept_w_s;
  assign w_addr = addr_t'(wr_ptr_r);
  assign r_addr = addr_t'(rd_ptr_r);

`ifdef FIFO_LEVEL_EN
  // Modulo subtraction gives 0..depth since pointers carry one extra bit.
  assign level = wr_ptr_r - rd_ptr_r;
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at ADDR_WIDTH=2 with a small register-file storage model.
module tb_fifo_ctrl;

  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic          wr;
  logic          rd;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
`ifdef FIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] mem [0:(1<<AW)-1];

  int vectors;
  int miscompares;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .full   (full),
    .empty  (empty),
    .wr_en  (wr_en),
    .w_addr (w_addr),
    .r_addr (r_addr)
`ifdef FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end
  assign r_data = mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_level(input string tag, input int exp);
`ifdef FIFO_LEVEL_EN
    chk(tag, 32'(level), 32'(exp));
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = 8'h00;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset / idle state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_waddr", 32'(w_addr), 32'd0);
    chk("rst_raddr", 32'(r_addr), 32'd0);
    chk("rst_wren", 32'(wr_en), 32'd0);
    chk_level("rst_level", 0);

    // Fill with A0..A3
    for (int i = 0; i < 4; i++) begin
      wr     = 1'b1;
      w_data = 8'hA0 + 8'(i);
      #1;
      chk("fill_wren", 32'(wr_en), 32'd1);
      cycle();
      chk("fill_empty", 32'(empty), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_waddr", 32'(w_addr), 32'd0);
    chk_level("fill_level", 4);

    // Write while full is ignored
    w_data = 8'hFF;
    #1;
    chk("ovf_wren", 32'(wr_en), 32'd0);
    cycle();
    wr = 1'b0;
    chk("ovf_waddr", 32'(w_addr), 32'd0);
    chk("ovf_full", 32'(full), 32'd1);
    chk_level("ovf_level", 4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(r_data), 32'hA0 + 32'(i));
      rd = 1'b1;
      cycle();
      chk("drain_full", 32'(full), 32'd0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_raddr", 32'(r_addr), 32'd0);

    // Read while empty is ignored
    cycle();
    rd = 1'b0;
    chk("udf_raddr", 32'(r_addr), 32'd0);
    chk("udf_empty", 32'(empty), 32'd1);

    // Preload two entries, then simultaneous wr&rd across the wrap
    wr = 1'b1;
    w_data = 8'hB0; cycle();
    w_data = 8'hB1; cycle();
    rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w_data = 8'hB2 + 8'(i);
      #1;
      chk("rw_data", 32'(r_data), 32'hB0 + 32'(i));
      cycle();
      chk_level("rw_level", 2);
      chk("rw_raddr", 32'(r_addr), 32'((i + 1) % 4));
      chk("rw_waddr", 32'(w_addr), 32'((i + 3) % 4));
      chk("rw_empty", 32'(empty), 32'd0);
    end

    // Top up to full, then wr&rd together: only the read goes through
    rd = 1'b0;
    w_data = 8'hC0; cycle();
    w_data = 8'hC1; cycle();
    chk("full2_full", 32'(full), 32'd1);
    rd = 1'b1;
    w_data = 8'hEE;
    #1;
    chk("full_rw_wren", 32'(wr_en), 32'd0);
    chk("full_rw_data", 32'(r_data), 32'hB6);
    cycle();
    wr = 1'b0;
    chk("full_rw_full", 32'(full), 32'd0);
    chk_level("full_rw_level", 3);
    chk("full_rw_waddr", 32'(w_addr), 32'd2);

    // Drain remaining B7, C0, C1
    chk("tail_d0", 32'(r_data), 32'hB7); cycle();
    chk("tail_d1", 32'(r_data), 32'hC0); cycle();
    chk("tail_d2", 32'(r_data), 32'hC1); cycle();
    chk("tail_empty", 32'(empty), 32'd1);

    // Empty + wr&rd together: only the write goes through
    wr = 1'b1;
    w_data = 8'hD0;
    #1;
    chk("empty_rw_wren", 32'(wr_en), 32'd1);
    cycle();
    wr = 1'b0;
    rd = 1'b0;
    chk("empty_rw_empty", 32'(empty), 32'd0);
    chk("empty_rw_data", 32'(r_data), 32'hD0);
    chk("empty_rw_raddr", 32'(r_addr), 32'd2);
    chk_level("empty_rw_level", 1);

    // Reset mid-stream with wr asserted
    wr = 1'b1;
    w_data = 8'h55;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wr    = 1'b0;
    #1;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_waddr", 32'(w_addr), 32'd0);
    chk("mrst_raddr", 32'(r_addr), 32'd0);
    chk_level("mrst_level", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fifo_ctrl
